// File: rtl/mux_rr_pkt_if.sv
// Handshake bundle for mux_rr_pkt: N valid/ready/last input streams on one side,
// and one registered valid/ready output stream on the other.
interface mux_rr_pkt_if #(
    parameter int W = 8,
    parameter int N = 4
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [SELW-1:0] out_sel;
    logic           out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/mux_rr_pkt.sv
// N-channel packet multiplexer: round-robin or fixed-priority arbitration, grant held
// from first beat to in_last, single registered output stage with valid/ready.
module mux_rr_pkt #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prio_mode,
    mux_rr_pkt_if.slave  bus
);
    localparam int SELW = $clog2(N);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    // (a + b) mod N for a, b < N, valid for non-power-of-2 N
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] a,
                                                 input logic [SELW-1:0] b);
        logic [SELW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (SELW+1)'(N))
            s = s - (SELW+1)'(N);
        return s[SELW-1:0];
    endfunction

    state_t          state_q, state_d;
    logic [SELW-1:0] own_q, own_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            rr_q, rr_d;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic            out_last_q;
    logic [SELW-1:0] out_sel_q;

    logic            load;
    logic            grant_vld;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] base;
    logic [SELW-1:0] cand;
    logic            xfer;
    logic            grant_last;

    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        base      = prio_mode ? '0 : ptr_q;
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        if (state_q == LOCK) begin
            grant_vld = 1'b1;
            grant     = own_q;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = wrap_add(base, SELW'(k));
                if (!grant_vld && bus.in_valid[cand]) begin
                    grant_vld = 1'b1;
                    grant     = cand;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (rst_n && load && grant_vld)
            bus.in_ready[grant] = 1'b1;
    end

    assign xfer       = grant_vld && load && bus.in_valid[grant];
    assign grant_last = bus.in_last[grant];

    // rr_q remembers the mode the packet was arbitrated under, so a prio_mode
    // change mid-packet cannot alter the pointer update at its last beat
    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (grant_last) begin
                        if (!prio_mode)
                            ptr_d = wrap_add(grant, SELW'(1));
                    end else begin
                        state_d = LOCK;
                        own_d   = grant;
                        rr_d    = !prio_mode;
                    end
                end
            end
            LOCK: begin
                if (xfer && grant_last) begin
                    state_d = IDLE;
                    if (rr_q)
                        ptr_d = wrap_add(own_q, SELW'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[int'(grant)*W +: W];
            out_last_q  <= grant_last;
            out_sel_q   <= grant;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_rr_pkt.sv
// Self-checking bench for mux_rr_pkt (W=8, N=4): vector table, directed packet
// sequences, then randomized traffic against a reference model.
module tb_mux_rr_pkt;
    logic clk = 1'b0;
    logic rst_n;
    logic prio_mode;

    mux_rr_pkt_if #(.W(8), .N(4)) bus ();

    mux_rr_pkt #(.W(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prio_mode (prio_mode),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        p;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        ordy;
        logic [3:0]  erdy;
        logic        eov;
        logic [1:0]  esel;
        logic [7:0]  edata;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // drive at posedge+1, check in_ready at posedge+3, check outputs at next posedge+1
    task automatic step(input string name, input logic p, input logic [3:0] v,
                        input logic [3:0] l, input logic [31:0] d, input logic ordy,
                        input logic [3:0] erdy, input logic eov, input logic [1:0] esel,
                        input logic [7:0] edata);
        prio_mode     = p;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #2;
        chk({name, "_rdy"}, 32'(bus.in_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk({name, "_out"}, {21'b0, bus.out_valid, bus.out_sel, bus.out_data},
            {21'b0, eov, esel, edata});
    endtask

    initial begin
        int          m_ptr, m_own, m_os, g;
        bit          m_lock, m_rr, m_ov, m_ol, has, ld, xf;
        logic [7:0]  m_od;
        logic        p;
        logic [3:0]  v, l, erdy;
        logic [31:0] d;
        logic        ordy;

        tbl[0] = '{1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[1] = '{1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[2] = '{1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[3] = '{1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[4] = '{1'b0, 4'hF, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[5] = '{1'b1, 4'hA, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[6] = '{1'b1, 4'hA, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[7] = '{1'b1, 4'hA, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[8] = '{1'b0, 4'hA, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[9] = '{1'b0, 4'hA, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};

        rst_n         = 1'b0;
        prio_mode     = 1'b0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            step($sformatf("tbl%0d", i), tbl[i].p, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].ordy,
                 tbl[i].erdy, tbl[i].eov, tbl[i].esel, tbl[i].edata);

        // reset mid-stream with every channel valid
        prio_mode     = 1'b0;
        bus.in_valid  = 4'hF;
        bus.in_last   = 4'hF;
        bus.in_data   = 32'hA3A2A1A0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid_out_data", 32'(bus.out_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rst_first", 0, 4'hF, 4'hF, 32'hA3A2A1A0, 1, 4'b0001, 1, 2'd0, 8'hA0);

        // packet lock: channel 2 holds grant for 3 beats while channel 1 waits
        step("pl_a", 0, 4'b0010, 4'b0010, 32'h0000_7700, 1, 4'b0010, 1, 2'd1, 8'h77);
        step("pl_b", 0, 4'b0110, 4'b0010, 32'h0011_5500, 1, 4'b0100, 1, 2'd2, 8'h11);
        step("pl_c", 0, 4'b0110, 4'b0010, 32'h0022_5500, 1, 4'b0100, 1, 2'd2, 8'h22);
        step("pl_d", 0, 4'b0110, 4'b0110, 32'h0033_5500, 1, 4'b0100, 1, 2'd2, 8'h33);
        step("pl_e", 0, 4'b1010, 4'b1010, 32'h4400_5500, 1, 4'b1000, 1, 2'd3, 8'h44);
        step("pl_f", 0, 4'b0010, 4'b0010, 32'h0000_5500, 1, 4'b0010, 1, 2'd1, 8'h55);

        // backpressure: 5A held for 5 cycles, then 6B follows without a bubble
        step("bp_load", 0, 4'b0001, 4'b0001, 32'h0000_005A, 1, 4'b0001, 1, 2'd0, 8'h5A);
        for (int i = 0; i < 5; i++)
            step("bp_hold", 0, 4'b0010, 4'b0010, 32'h0000_6B00, 0, 4'b0000, 1, 2'd0, 8'h5A);
        step("bp_release", 0, 4'b0010, 4'b0010, 32'h0000_6B00, 1, 4'b0010, 1, 2'd1, 8'h6B);
        step("bp_ch3", 0, 4'b1000, 4'b1000, 32'h7C00_0000, 1, 4'b1000, 1, 2'd3, 8'h7C);

        // fixed-mode packet; switching to round-robin mid-packet leaves ptr at 0
        step("fp_lock", 1, 4'b1010, 4'b0000, 32'hC300_C100, 1, 4'b0010, 1, 2'd1, 8'hC1);
        step("fp_switch", 0, 4'b1010, 4'b0010, 32'hC300_C200, 1, 4'b0010, 1, 2'd1, 8'hC2);
        step("fp_after", 0, 4'b1010, 4'b1010, 32'hC300_C500, 1, 4'b0010, 1, 2'd1, 8'hC5);

        // owner gap: channel 0 pauses mid-packet, channel 3 must wait
        step("og_start", 0, 4'b0001, 4'b0000, 32'hE300_00D0, 1, 4'b0001, 1, 2'd0, 8'hD0);
        step("og_gap1", 0, 4'b1000, 4'b1000, 32'hE300_0000, 1, 4'b0001, 0, 2'd0, 8'hD0);
        step("og_gap2", 0, 4'b1000, 4'b1000, 32'hE300_0000, 1, 4'b0001, 0, 2'd0, 8'hD0);
        step("og_resume", 0, 4'b1001, 4'b1001, 32'hE300_00D1, 1, 4'b0001, 1, 2'd0, 8'hD1);
        step("og_ch3", 0, 4'b1000, 4'b1000, 32'hE300_0000, 1, 4'b1000, 1, 2'd3, 8'hE3);

        // randomized traffic against a packet-level reference model
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_own  = 0;
        m_lock = 0;
        m_rr   = 0;
        m_ov   = 0;
        m_ol   = 0;
        m_od   = '0;
        m_os   = 0;
        p      = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 19) == 0)
                p = ~p;
            v = 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++)
                l[b] = ($urandom_range(0, 2) == 0);
            d    = $urandom;
            ordy = ($urandom_range(0, 3) != 0);
            prio_mode     = p;
            bus.in_valid  = v;
            bus.in_last   = l;
            bus.in_data   = d;
            bus.out_ready = ordy;
            #2;

            ld  = !m_ov || ordy;
            has = 0;
            g   = 0;
            if (m_lock) begin
                has = 1;
                g   = m_own;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = ((p ? 0 : m_ptr) + k) % 4;
                    if (!has && v[idx]) begin
                        has = 1;
                        g   = idx;
                    end
                end
            end
            erdy = (has && ld) ? 4'(1 << g) : 4'b0000;
            chk("rand_rdy", 32'(bus.in_ready), 32'(erdy));

            xf = has && ld && v[g];
            if (xf) begin
                m_od = d[8*g +: 8];
                m_ol = l[g];
                m_os = g;
                m_ov = 1;
                if (!m_lock) begin
                    if (l[g]) begin
                        if (!p) m_ptr = (g + 1) % 4;
                    end else begin
                        m_lock = 1;
                        m_own  = g;
                        m_rr   = !p;
                    end
                end else if (l[g]) begin
                    m_lock = 0;
                    if (m_rr) m_ptr = (m_own + 1) % 4;
                end
            end else if (ordy) begin
                m_ov = 0;
            end

            @(posedge clk);
            #1;
            chk("rand_out", {20'b0, bus.out_last, bus.out_valid, bus.out_sel, bus.out_data},
                {20'b0, m_ol, m_ov, 2'(m_os), m_od});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
